neander_alu_ctrl: RTL
=====================

// Module: neander_alu_ctrl
// PURPOSE
//  Sequencing/writeback stage wrapped around the combinational neander_alu. Captures an op
//  request, drives the ALU from AC plus a latched operand, and holds the inputs stable for
//  a programmable number of extra cycles on MUL/DIV/MOD. Writes result to AC, high/remainder
//  byte to Y, and updates N/Z/C. Sits between the NEANDER-X control FSM and neander_alu.
// PARAMETERS
//  MULDIV_CYCLES  4  extra WAIT cycles for ops 1001/1010/1011 (0 allowed = single-cycle)
// PORTS
//  clk          in   1  system clock; all state changes on rising edge
//  reset        in   1  synchronous, active-high reset
//  start        in   1  request pulse; sampled only in IDLE
//  op           in   4  ALU opcode (0000-1011 legal, 1100-1111 illegal)
//  operand      in   8  B operand (memory data), latched when start accepted
//  ac_ld        in   1  direct AC load (LDA); honoured only in IDLE
//  ac_ld_data   in   8  value for ac_ld
//  alu_a        out  8  to neander_alu.a   (= ac)
//  alu_b        out  8  to neander_alu.b   (= latched operand)
//  alu_op       out  4  to neander_alu.alu_op (= latched op)
//  alu_result   in   8  from neander_alu.result
//  alu_mul_high in   8  from neander_alu.mul_high
//  alu_carry    in   1  from neander_alu.carry_out
//  ac           out  8  accumulator
//  y            out  8  Y register (MUL high byte / DIV remainder / MOD quotient)
//  flag_n       out  1  negative flag
//  flag_z       out  1  zero flag
//  flag_c       out  1  carry/borrow/error flag
//  busy         out  1  high in EXEC, WAIT, WB
//  done         out  1  one-cycle pulse in WB
//  illegal      out  1  one-cycle pulse in WB when latched op >= 1100
// BEHAVIOUR
//  Reset: state=IDLE, ac=0, y=0, N=0, Z=1, C=0, busy=0, done=0, illegal=0, op/operand latches=0.
//  FSM IDLE -> EXEC -> [WAIT x MULDIV_CYCLES, MUL/DIV/MOD only] -> WB -> IDLE.
//  IDLE: ac_ld=1 -> ac<=ac_ld_data, N/Z from data, C unchanged; start ignored that cycle.
//        else start=1 -> latch op/operand, go EXEC. start outside IDLE dropped (no queue).
//  alu_a/alu_b/alu_op are registers (or ac), constant throughout EXEC/WAIT; ac not modified there.
//  Result capture on the edge leaving EXEC (simple ops) or the last WAIT cycle (mul/div):
//    legal op: ac<=alu_result; N<=alu_result[7]; Z<=(alu_result==0).
//    y<=alu_mul_high for 1001/1010/1011 only; y unchanged otherwise.
//    C<=alu_carry for ADD,SUB,SHL,SHR,NEG,MUL,DIV,MOD; C unchanged for AND,OR,XOR,NOT.
//    illegal op: ac, y, N, Z, C all unchanged; illegal=1 in WB.
//  WB: done=1 for exactly one cycle; new ac/y/flags already visible; next state IDLE.
//  Latency (start sampled at edge 0): simple op done high in cycle 2; mul/div op done high
//    in cycle 2+MULDIV_CYCLES. Back-to-back: next start accepted in cycle after WB.
//  WAIT counter width $clog2(MULDIV_CYCLES+1); loads MULDIV_CYCLES-1 on EXEC->WAIT, exits at 0.
//  Reset mid-operation (any state): next cycle IDLE with reset values; no partial writeback.
// TESTING
//  1 reset -> ac=00 y=00 N=0 Z=1 C=0 busy=0; assert reset in WAIT -> IDLE, ac=00, no done.
//  2 ac_ld 7F; start ADD 01 -> done exactly 2 cycles after start; ac=80 N=1 Z=0 C=0.
//  3 ac_ld FF; ADD 01 -> ac=00 Z=1 C=1; then AND 0F -> ac=00 Z=1, C stays 1.
//  4 MULDIV_CYCLES=4: ac_ld 10; MUL 20 -> done at cycle 6; ac=00 y=02 Z=1 C=1; alu_a/b stable.
//  5 ac_ld 2A; DIV 00 -> ac=FF y=2A C=1 N=1; then ac_ld 07, MOD 03 -> ac=01 y=02 C=0.
//  6 op=1100 -> done+illegal same cycle, ac/y/flags unchanged; start while busy ignored.

Source files
------------

// File: rtl/neander_alu_ctrl.sv
// Sequencing and writeback stage around the combinational neander_alu. It latches an op request,
// holds the ALU inputs stable through EXEC/WAIT, and writes the result to AC, Y and the N/Z/C flags.
// Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 NEG, 9 MUL, A DIV, B MOD.
module neander_alu_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_op,
  input  logic [7:0] i_operand,
  input  logic       i_ac_ld,
  input  logic [7:0] i_ac_ld_data,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [3:0] o_alu_op,
  input  logic [7:0] i_alu_result,
  input  logic [7:0] i_alu_mul_high,
  input  logic       i_alu_carry,
  output logic [7:0] o_ac,
  output logic [7:0] o_y,
  output logic       o_flag_n,
  output logic       o_flag_z,
  output logic       o_flag_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_illegal
);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpXor = 4'h4;
  localparam logic [3:0] OpNot = 4'h5;
  localparam logic [3:0] OpShl = 4'h6;
  localparam logic [3:0] OpShr = 4'h7;
  localparam logic [3:0] OpNeg = 4'h8;
  localparam logic [3:0] OpMul = 4'h9;
  localparam logic [3:0] OpDiv = 4'hA;
  localparam logic [3:0] OpMod = 4'hB;

  // A zero-cycle configuration still needs a 1-bit counter to keep the declaration legal.
  localparam int unsigned CntW    = (MULDIV_CYCLES > 0) ? $clog2(MULDIV_CYCLES + 1) : 1;
  localparam int unsigned CntLoad = (MULDIV_CYCLES > 0) ? MULDIV_CYCLES - 1 : 0;
  localparam bit          HasWait = (MULDIV_CYCLES > 0);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWait,
    StWb
  } state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [3:0]      r_op, w_op_next;
  logic [7:0]      r_operand, w_operand_next;
  logic [7:0]      r_ac, w_ac_next;
  logic [7:0]      r_y, w_y_next;
  logic            r_n, w_n_next;
  logic            r_z, w_z_next;
  logic            r_c, w_c_next;

  logic w_is_muldiv;
  logic w_is_illegal;
  logic w_updates_c;
  logic w_capture;

  always_comb begin
    w_is_muldiv  = (r_op == OpMul) || (r_op == OpDiv) || (r_op == OpMod);
    w_is_illegal = (r_op >= 4'hC);
    w_updates_c  = 1'b0;
    unique case (r_op)
      OpAdd, OpSub, OpShl, OpShr, OpNeg, OpMul, OpDiv, OpMod: w_updates_c = 1'b1;
      OpAnd, OpOr, OpXor, OpNot: w_updates_c = 1'b0;
      default: w_updates_c = 1'b0;
    endcase
  end

  // Result is taken on the edge leaving EXEC for simple ops, or leaving the last WAIT cycle.
  assign w_capture = ((r_state == StExec) && !(w_is_muldiv && HasWait)) ||
                     ((r_state == StWait) && (r_cnt == '0));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (!i_ac_ld && i_start) begin
          w_state_next = StExec;
        end
      end
      StExec: begin
        if (w_is_muldiv && HasWait) begin
          w_state_next = StWait;
          w_cnt_next   = CntW'(CntLoad);
        end else begin
          w_state_next = StWb;
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_next = StWb;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StWb: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    w_op_next      = r_op;
    w_operand_next = r_operand;
    w_ac_next      = r_ac;
    w_y_next       = r_y;
    w_n_next       = r_n;
    w_z_next       = r_z;
    w_c_next       = r_c;
    if (r_state == StIdle) begin
      if (i_ac_ld) begin
        w_ac_next = i_ac_ld_data;
        w_n_next  = i_ac_ld_data[7];
        w_z_next  = (i_ac_ld_data == 8'h00);
      end else if (i_start) begin
        w_op_next      = i_op;
        w_operand_next = i_operand;
      end
    end
    if (w_capture && !w_is_illegal) begin
      w_ac_next = i_alu_result;
      w_n_next  = i_alu_result[7];
      w_z_next  = (i_alu_result == 8'h00);
      if (w_is_muldiv) begin
        w_y_next = i_alu_mul_high;
      end
      if (w_updates_c) begin
        w_c_next = i_alu_carry;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_op      <= 4'h0;
      r_operand <= 8'h00;
      r_ac      <= 8'h00;
      r_y       <= 8'h00;
      r_n       <= 1'b0;
      r_z       <= 1'b1;
      r_c       <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_op      <= w_op_next;
      r_operand <= w_operand_next;
      r_ac      <= w_ac_next;
      r_y       <= w_y_next;
      r_n       <= w_n_next;
      r_z       <= w_z_next;
      r_c       <= w_c_next;
    end
  end

  assign o_alu_a   = r_ac;
  assign o_alu_b   = r_operand;
  assign o_alu_op  = r_op;
  assign o_ac      = r_ac;
  assign o_y       = r_y;
  assign o_flag_n  = r_n;
  assign o_flag_z  = r_z;
  assign o_flag_c  = r_c;
  assign o_busy    = (r_state != StIdle);
  assign o_done    = (r_state == StWb);
  assign o_illegal = (r_state == StWb) && w_is_illegal;

endmodule
